// File: rtl/trigger_timestamp_capture.sv
// trigger_timestamp_capture
//    Watches the trigger line from the delayed trigger generator and the
//    counter_reset period pulses. Records the sample count, the period index
//    and the phase within the period at which the trigger fired, so software
//    can align sample buffers. The presample offset is removed from the
//    captured sample count.
//
// Ports
//    clk_i            sample clock
//    reset_i          synchronous active-high reset
//    trigger_i        trigger line (same clock domain)
//    counter_reset_i  one-cycle period-boundary pulse
//    arm_i            one-cycle pulse, arms capture from IDLE
//    clear_i          one-cycle pulse, discards result and returns to IDLE
//    presamples_i     offset subtracted from the captured sample count
//    timestamp_o      captured sample count minus presamples (floored at 0)
//    period_index_o   counter_reset pulses seen between arm and trigger
//    phase_o          cycles since last counter_reset at the trigger
//    valid_o          a captured result is held
//    armed_status_o   waiting for a trigger edge
//    missed_count_o   trigger edges seen while a result is held
//
// state     | meaning
// ST_IDLE   | not armed, trigger edges ignored
// ST_ARMED  | waiting for a trigger edge
// ST_CAPT   | result held, further edges counted as missed
module trigger_timestamp_capture #(
   parameter int CNT_WIDTH    = 64,
   parameter int PERIOD_WIDTH = 32,
   parameter int MISS_WIDTH   = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    trigger_i,
   input  logic                    counter_reset_i,
   input  logic                    arm_i,
   input  logic                    clear_i,
   input  logic [31:0]             presamples_i,
   output logic [CNT_WIDTH-1:0]    timestamp_o,
   output logic [PERIOD_WIDTH-1:0] period_index_o,
   output logic [PERIOD_WIDTH-1:0] phase_o,
   output logic                    valid_o,
   output logic                    armed_status_o,
   output logic [MISS_WIDTH-1:0]   missed_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CAPT  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = PERIOD_WIDTH'(1);
   localparam logic [MISS_WIDTH-1:0]   MISS_ONE = MISS_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    sample_cnt_q;
   logic [PERIOD_WIDTH-1:0] phase_cnt_q;
   logic [PERIOD_WIDTH-1:0] period_cnt_q;
   logic                    trigger_q;
   logic                    valid_q;
   logic                    armed_q;
   logic [CNT_WIDTH-1:0]    timestamp_q;
   logic [PERIOD_WIDTH-1:0] period_index_q;
   logic [PERIOD_WIDTH-1:0] phase_q;
   logic [MISS_WIDTH-1:0]   missed_q;

   logic                    trig_edge;
   logic                    arm_accept;
   logic                    capture;
   logic                    missed_inc;
   logic [CNT_WIDTH-1:0]    presamples_ext;
   logic [CNT_WIDTH-1:0]    timestamp_d;
   logic [PERIOD_WIDTH-1:0] phase_sat_inc;
   logic [PERIOD_WIDTH-1:0] period_sat_inc;
   logic [PERIOD_WIDTH-1:0] period_index_d;
   logic [PERIOD_WIDTH-1:0] phase_d;
   logic [MISS_WIDTH-1:0]   missed_sat_inc;

   // trigger_q comes out of reset high so a line already high is not an edge
   assign trig_edge  = trigger_i & ~trigger_q;
   assign arm_accept = (state_q == ST_IDLE)  & arm_i    & ~clear_i;
   assign capture    = (state_q == ST_ARMED) & trig_edge & ~clear_i;
   assign missed_inc = (state_q == ST_CAPT)  & trig_edge & ~clear_i;

   assign presamples_ext = CNT_WIDTH'(presamples_i);
   // floor at zero instead of wrapping when the trigger comes early
   assign timestamp_d = (sample_cnt_q < presamples_ext) ? '0
                                                         : sample_cnt_q - presamples_ext;

   assign phase_sat_inc  = (&phase_cnt_q)  ? phase_cnt_q  : phase_cnt_q  + PER_ONE;
   assign period_sat_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + PER_ONE;
   assign missed_sat_inc = (&missed_q)     ? missed_q     : missed_q     + MISS_ONE;

   // a boundary in the edge cycle has not reached the counters yet
   assign phase_d        = counter_reset_i ? '0 : phase_cnt_q;
   assign period_index_d = counter_reset_i ? period_sat_inc : period_cnt_q;

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  if (arm_i)     state_d = ST_ARMED;
            ST_ARMED: if (trig_edge) state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_CAPT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == ST_CAPT);
         armed_q <= (state_d == ST_ARMED);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sample_cnt_q   <= '0;
         phase_cnt_q    <= '0;
         period_cnt_q   <= '0;
         trigger_q      <= 1'b1;
         timestamp_q    <= '0;
         period_index_q <= '0;
         phase_q        <= '0;
         missed_q       <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_q + CNT_ONE;
         phase_cnt_q  <= counter_reset_i ? '0 : phase_sat_inc;
         trigger_q    <= trigger_i;

         if (arm_accept) begin
            period_cnt_q <= '0;
         end else if ((state_q == ST_ARMED) && counter_reset_i) begin
            period_cnt_q <= period_sat_inc;
         end

         if (clear_i) begin
            timestamp_q    <= '0;
            period_index_q <= '0;
            phase_q        <= '0;
            missed_q       <= '0;
         end else if (capture) begin
            timestamp_q    <= timestamp_d;
            period_index_q <= period_index_d;
            phase_q        <= phase_d;
         end else if (missed_inc) begin
            missed_q <= missed_sat_inc;
         end
      end
   end

   assign timestamp_o    = timestamp_q;
   assign period_index_o = period_index_q;
   assign phase_o        = phase_q;
   assign valid_o        = valid_q;
   assign armed_status_o = armed_q;
   assign missed_count_o = missed_q;

endmodule
